// File: rtl/falafel_pkg.sv
// Shared types for the falafel memory subsystem: arbiter state encoding and
// the request bundle that each requester presents to the shared port.
package falafel_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_RSP
    } arb_state_e;

    typedef struct packed {
        logic              is_write;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    // Index width that stays legal when there is only one requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/falafel_rr_picker.sv
// Combinational round-robin picker: returns the first set bit of req,
// searching upward from ptr with wrap-around.
module falafel_rr_picker
    import falafel_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin : pick
        logic [IDX_W-1:0] cand;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/falafel_mem_arbiter.sv
// Round-robin arbiter sharing the single falafel memory port between N_REQ
// requesters; one transaction in flight, response routed to the granted one.
module falafel_mem_arbiter
    import falafel_pkg::*;
#(
    parameter  int N_REQ     = 2,
    parameter  int WRITE_RSP = 1,
    parameter  int CNT_W     = 32,
    localparam int IDX_W     = idx_width(N_REQ)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_REQ-1:0]             req_val_i,
    output logic [N_REQ-1:0]             req_rdy_o,
    input  logic [N_REQ-1:0]             req_is_write_i,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_addr_i,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]             rsp_val_o,
    input  logic [N_REQ-1:0]             rsp_rdy_i,
    output logic [DATA_W-1:0]            rsp_data_o,
    output logic                         mem_req_val_o,
    input  logic                         mem_req_rdy_i,
    output logic                         mem_req_is_write_o,
    output logic [DATA_W-1:0]            mem_req_addr_o,
    output logic [DATA_W-1:0]            mem_req_data_o,
    input  logic                         mem_rsp_val_i,
    output logic                         mem_rsp_rdy_o,
    input  logic [DATA_W-1:0]            mem_rsp_data_i,
    output logic                         busy_o,
    output logic [IDX_W-1:0]             grant_o,
    output logic [CNT_W-1:0]             txn_cnt_o
);

    arb_state_e              state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        grant_q;
    logic [CNT_W-1:0]        txn_cnt;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;
    mem_req_t [N_REQ-1:0]    reqs;
    mem_req_t                sel;
    logic                    req_hs;
    logic                    rsp_hs;
    logic                    write_done;
    logic                    complete;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            reqs[i] = '{is_write: req_is_write_i[i], addr: req_addr_i[i], data: req_data_i[i]};
        end
    end

    assign sel        = reqs[grant_q];
    assign req_hs     = (state == ARB_ISSUE) && req_val_i[grant_q] && mem_req_rdy_i;
    assign rsp_hs     = (state == ARB_WAIT_RSP) && mem_rsp_val_i && rsp_rdy_i[grant_q];
    // Posted writes finish at the request handshake and never wait for memory.
    assign write_done = req_hs && sel.is_write && (WRITE_RSP == 0);
    assign complete   = write_done || rsp_hs;

    falafel_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req (req_val_i),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ARB_IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            txn_cnt <= '0;
        end else begin
            if (complete) begin
                rr_ptr  <= (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                txn_cnt <= txn_cnt + 1'b1;
            end
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        state   <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    // A dropped request is an abort: no completion, pointer kept.
                    if (!req_val_i[grant_q]) begin
                        state <= ARB_IDLE;
                    end else if (mem_req_rdy_i) begin
                        state <= write_done ? ARB_IDLE : ARB_WAIT_RSP;
                    end
                end
                ARB_WAIT_RSP: begin
                    if (rsp_hs) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        req_rdy_o          = '0;
        rsp_val_o          = '0;
        rsp_data_o         = '0;
        mem_req_val_o      = 1'b0;
        mem_req_is_write_o = 1'b0;
        mem_req_addr_o     = '0;
        mem_req_data_o     = '0;
        mem_rsp_rdy_o      = 1'b0;
        case (state)
            ARB_ISSUE: begin
                mem_req_val_o      = req_val_i[grant_q];
                req_rdy_o[grant_q] = mem_req_rdy_i;
                mem_req_is_write_o = sel.is_write;
                mem_req_addr_o     = sel.addr;
                mem_req_data_o     = sel.data;
            end
            ARB_WAIT_RSP: begin
                rsp_val_o[grant_q] = mem_rsp_val_i;
                mem_rsp_rdy_o      = rsp_rdy_i[grant_q];
                rsp_data_o         = mem_rsp_data_i;
            end
            default: ;
        endcase
    end

    assign busy_o    = (state != ARB_IDLE);
    assign grant_o   = grant_q;
    assign txn_cnt_o = txn_cnt;

endmodule

// File: tb/tb_falafel_mem_arbiter.sv
// Self-checking bench for falafel_mem_arbiter (2 requesters, posted writes,
// 2-bit counter) against a queue-based round-robin reference model.
module tb_falafel_mem_arbiter;
    import falafel_pkg::*;

    localparam int N  = 2;
    localparam int CW = 2;

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b1;
    logic [N-1:0]             req_val_i = '0;
    logic [N-1:0]             req_rdy_o;
    logic [N-1:0]             req_is_write_i = '0;
    logic [N-1:0][DATA_W-1:0] req_addr_i = '0;
    logic [N-1:0][DATA_W-1:0] req_data_i = '0;
    logic [N-1:0]             rsp_val_o;
    logic [N-1:0]             rsp_rdy_i = '0;
    logic [DATA_W-1:0]        rsp_data_o;
    logic                     mem_req_val_o;
    logic                     mem_req_rdy_i = 1'b0;
    logic                     mem_req_is_write_o;
    logic [DATA_W-1:0]        mem_req_addr_o;
    logic [DATA_W-1:0]        mem_req_data_o;
    logic                     mem_rsp_val_i = 1'b0;
    logic                     mem_rsp_rdy_o;
    logic [DATA_W-1:0]        mem_rsp_data_i = '0;
    logic                     busy_o;
    logic [0:0]               grant_o;
    logic [CW-1:0]            txn_cnt_o;

    always #5 clk_i = ~clk_i;

    falafel_mem_arbiter #(.N_REQ(N), .WRITE_RSP(0), .CNT_W(CW)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .req_val_i          (req_val_i),
        .req_rdy_o          (req_rdy_o),
        .req_is_write_i     (req_is_write_i),
        .req_addr_i         (req_addr_i),
        .req_data_i         (req_data_i),
        .rsp_val_o          (rsp_val_o),
        .rsp_rdy_i          (rsp_rdy_i),
        .rsp_data_o         (rsp_data_o),
        .mem_req_val_o      (mem_req_val_o),
        .mem_req_rdy_i      (mem_req_rdy_i),
        .mem_req_is_write_o (mem_req_is_write_o),
        .mem_req_addr_o     (mem_req_addr_o),
        .mem_req_data_o     (mem_req_data_o),
        .mem_rsp_val_i      (mem_rsp_val_i),
        .mem_rsp_rdy_o      (mem_rsp_rdy_o),
        .mem_rsp_data_i     (mem_rsp_data_i),
        .busy_o             (busy_o),
        .grant_o            (grant_o),
        .txn_cnt_o          (txn_cnt_o)
    );

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } treq_t;

    treq_t rq [N][$];
    int    total = 0;
    int    bad   = 0;
    int    m_rr  = 0;
    int    m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first valid requester at or after the model pointer.
    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (req_val_i[i]) return i;
        end
        return -1;
    endfunction

    task automatic complete_model(input int g);
        m_rr  = (g + 1) % N;
        m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    task automatic load(input int r);
        if (rq[r].size() > 0) begin
            req_val_i[r]      = 1'b1;
            req_is_write_i[r] = rq[r][0].w;
            req_addr_i[r]     = rq[r][0].a;
            req_data_i[r]     = rq[r][0].d;
        end else begin
            req_val_i[r] = 1'b0;
        end
    endtask

    task automatic push(input int r, input logic w, input logic [31:0] a, input logic [31:0] d);
        treq_t t;
        t.w = w;
        t.a = a;
        t.d = d;
        rq[r].push_back(t);
    endtask

    task automatic push_rand(input int r);
        push(r, 1'($urandom), $urandom, $urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    32'(busy_o), 0);
        check({tag, "_grant"},   32'(grant_o), 0);
        check({tag, "_txn"},     32'(txn_cnt_o), 0);
        check({tag, "_req_rdy"}, 32'(req_rdy_o), 0);
        check({tag, "_rsp_val"}, 32'(rsp_val_o), 0);
        check({tag, "_mem_val"}, 32'(mem_req_val_o), 0);
        check({tag, "_mem_rdy"}, 32'(mem_rsp_rdy_o), 0);
        check({tag, "_mem_adr"}, mem_req_addr_o, 0);
    endtask

    // One full transaction, entered and left at a falling edge with the DUT idle.
    task automatic step_txn(input int istall, input int rlat, input int rstall, input logic [31:0] rdata);
        int    g;
        treq_t t;
        g = pick();
        check("req_present", 32'(g >= 0), 1);
        if (g < 0) return;
        t = rq[g][0];
        #1;
        check("idle_busy",    32'(busy_o), 0);
        check("idle_mem_val", 32'(mem_req_val_o), 0);
        check("idle_req_rdy", 32'(req_rdy_o), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        mem_req_rdy_i = 1'b0;
        rsp_rdy_i     = '1;
        mem_rsp_val_i = 1'($urandom);
        for (int c = 0; c <= istall; c++) begin
            if (c == istall) mem_req_rdy_i = 1'b1;
            #1;
            check("grant",         32'(grant_o), g);
            check("issue_busy",    32'(busy_o), 1);
            check("issue_mem_val", 32'(mem_req_val_o), 1);
            check("issue_wr",      32'(mem_req_is_write_o), 32'(t.w));
            check("issue_addr",    mem_req_addr_o, t.a);
            check("issue_data",    mem_req_data_o, t.d);
            check("issue_req_rdy", 32'(req_rdy_o), (c == istall) ? (1 << g) : 0);
            check("issue_rsp_rdy", 32'(mem_rsp_rdy_o), 0);
            check("issue_rsp_val", 32'(rsp_val_o), 0);
            @(posedge clk_i);
            @(negedge clk_i);
        end
        mem_req_rdy_i = 1'b0;
        mem_rsp_val_i = 1'b0;
        rsp_rdy_i     = '0;
        void'(rq[g].pop_front());
        load(g);
        if (t.w) begin
            complete_model(g);
            #1;
            check("wr_busy",    32'(busy_o), 0);
            check("wr_rsp_rdy", 32'(mem_rsp_rdy_o), 0);
            check("wr_txn",     32'(txn_cnt_o), m_cnt);
        end else begin
            for (int c = 0; c < rlat; c++) begin
                rsp_rdy_i = N'($urandom);
                #1;
                check("wait_busy",    32'(busy_o), 1);
                check("wait_mem_val", 32'(mem_req_val_o), 0);
                check("wait_rsp_val", 32'(rsp_val_o), 0);
                check("wait_rsp_rdy", 32'(mem_rsp_rdy_o), 32'(rsp_rdy_i[g]));
                @(posedge clk_i);
                @(negedge clk_i);
            end
            mem_rsp_val_i  = 1'b1;
            mem_rsp_data_i = rdata;
            for (int c = 0; c <= rstall; c++) begin
                rsp_rdy_i = (c == rstall) ? N'(1 << g) : N'(~(1 << g));
                #1;
                check("rsp_val",  32'(rsp_val_o), 1 << g);
                check("rsp_data", rsp_data_o, rdata);
                check("rsp_rdy",  32'(mem_rsp_rdy_o), 32'(c == rstall));
                @(posedge clk_i);
                @(negedge clk_i);
            end
            mem_rsp_val_i = 1'b0;
            rsp_rdy_i     = '0;
            complete_model(g);
            #1;
            check("rd_busy", 32'(busy_o), 0);
            check("rd_txn",  32'(txn_cnt_o), m_cnt);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        load(0);
        load(1);
        while ((rq[0].size() + rq[1].size()) > 0 && guard < 64) begin
            step_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
            guard++;
        end
        check("drain_bound", 32'(rq[0].size() + rq[1].size()), 0);
    endtask

    initial begin
        // Reset with requests asserted: everything must stay inactive.
        req_val_i = '1;
        @(negedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("reset");
        req_val_i = '0;
        rst_i     = 1'b0;
        @(negedge clk_i);

        // Single read, 2-cycle memory latency.
        push(0, 1'b0, 32'h100, 32'h0);
        load(0);
        step_txn(0, 2, 0, 32'hDEAD_BEEF);

        // Contention: four reads from each requester, valid held throughout.
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 32'h200 + 32'(i), 32'h0);
            push(1, 1'b0, 32'h300 + 32'(i), 32'h0);
        end
        drain();

        // Posted write from requester 1.
        push(1, 1'b1, 32'h40, 32'h1234);
        load(1);
        step_txn(0, 0, 0, 32'h0);

        // Abort in ISSUE: no completion, pointer untouched.
        req_val_i[0] = 1'b1;
        req_addr_i[0] = 32'h500;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("abort_grant",   32'(grant_o), 0);
        check("abort_mem_val", 32'(mem_req_val_o), 1);
        req_val_i[0] = 1'b0;
        #1;
        check("abort_drop_val", 32'(mem_req_val_o), 0);
        check("abort_req_rdy",  32'(req_rdy_o), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("abort_busy", 32'(busy_o), 0);
        check("abort_txn",  32'(txn_cnt_o), m_cnt);

        // Stray memory response while idle.
        mem_rsp_val_i = 1'b1;
        rsp_rdy_i     = '1;
        #1;
        check("stray_rsp_rdy", 32'(mem_rsp_rdy_o), 0);
        check("stray_rsp_val", 32'(rsp_val_o), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        mem_rsp_val_i = 1'b0;
        rsp_rdy_i     = '0;

        // Both valid after the abort: pointer still selects requester 0.
        push(0, 1'b0, 32'h600, 32'h0);
        push(1, 1'b0, 32'h700, 32'h0);
        load(0);
        load(1);
        step_txn(5, 1, 3, $urandom);
        step_txn(5, 1, 3, $urandom);

        // Reset in the middle of WAIT_RSP.
        push(0, 1'b0, 32'h800, 32'h0);
        load(0);
        @(posedge clk_i);
        @(negedge clk_i);
        mem_req_rdy_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        mem_req_rdy_i = 1'b0;
        #1;
        check("pre_reset_busy", 32'(busy_o), 1);
        rst_i = 1'b1;
        #1;
        check_reset_outputs("midrst");
        rq[0].delete();
        rq[1].delete();
        req_val_i = '0;
        m_rr  = 0;
        m_cnt = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Five random completions wrap the 2-bit counter to 1.
        for (int i = 0; i < 5; i++) push_rand(int'($urandom_range(0, 1)));
        drain();
        check("wrap_txn", 32'(txn_cnt_o), 1);

        // Longer randomized mix.
        for (int i = 0; i < 12; i++) push_rand(int'($urandom_range(0, 1)));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
